// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller and its helpers.
package exc_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    RUN      = 3'd0,
    FLUSH    = 3'd1,
    REDIRECT = 3'd2,
    HANDLER  = 3'd3,
    HALT     = 3'd4
  } exc_state_e;

  // Cause codes reported in ESR.
  localparam logic [3:0] NONE     = 4'd0;
  localparam logic [3:0] BADOP    = 4'd1;
  localparam logic [3:0] IRQ      = 4'd2;
  localparam logic [3:0] MEMF     = 4'd3;
  localparam logic [3:0] ERET_RUN = 4'd4;

  // Handler entry address used when the top-level parameter is left alone.
  localparam logic [63:0] DEFAULT_VECTOR = 64'hD8;

  // Width of the flush-cycle counter.
  localparam int CNT_W = 3;

endpackage

// File: rtl/exc_prio.sv
// Combinational priority encoder for exception sources.
// Order: memory fault > bad opcode > ERET > enabled external interrupt.
module exc_prio
  import exc_pkg::*;
(
  input  logic       mem_fault,
  input  logic       bad_opcode,
  input  logic       eret,
  input  logic       ext_irq,
  input  logic       ie,
  output logic       valid,
  output logic [3:0] cause
);

  // Pick the highest-priority active source.
  always_comb begin
    valid = 1'b1;
    cause = NONE;
    if (mem_fault) begin
      cause = MEMF;
    end else if (bad_opcode) begin
      cause = BADOP;
    end else if (eret) begin
      cause = ERET_RUN;
    end else if (ext_irq && ie) begin
      cause = IRQ;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer around the execute stage: prioritises
// sources, latches return PC and cause, flushes the pipe, redirects fetch
// to the handler vector and back again on ERET.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int           N            = 64,
  parameter logic [N-1:0] VECTOR       = N'(DEFAULT_VECTOR),
  parameter int           FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         MemFault_M,
  input  logic         BadOpcode_E,
  input  logic         ERet_E,
  input  logic         ExtIRQ,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] PC_M,
  output logic         IrqAck,
  output logic         Flush_D,
  output logic         Flush_E,
  output logic         Flush_M,
  output logic         Stall_F,
  output logic         ExcRedirect,
  output logic [N-1:0] ExcPC,
  output logic [N-1:0] ERR,
  output logic [3:0]   ESR,
  output logic         IE,
  output logic         Halt
);

  generate
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
      $error("exception_ctrl: FLUSH_CYCLES must be in 1..7");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

  exc_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             prio_vld;
  logic [3:0]       prio_cause;

  // ERET only counts as an exception source while running normally; in the
  // handler it is a return. IE is clear in the handler, so only faults
  // reach the encoder there, which is exactly the double-fault set.
  exc_prio u_prio (
    .mem_fault  (MemFault_M),
    .bad_opcode (BadOpcode_E),
    .eret       (ERet_E && (state == RUN)),
    .ext_irq    (ExtIRQ),
    .ie         (IE),
    .valid      (prio_vld),
    .cause      (prio_cause)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (prio_vld) state_nxt = FLUSH;
      FLUSH:    if (cnt == CNT_LAST) state_nxt = REDIRECT;
      REDIRECT: state_nxt = HANDLER;
      HANDLER: begin
        if (prio_vld) begin
          state_nxt = HALT;
        end else if (ERet_E) begin
          state_nxt = RUN;
        end
      end
      HALT:     state_nxt = HALT;
      default:  state_nxt = RUN;
    endcase
  end

  // Flush counter, return PC, cause and interrupt-enable registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      ERR <= '0;
      ESR <= NONE;
      IE  <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (prio_vld) begin
            // A faulting load/store restarts at its own PC; everything else
            // (including interrupts) restarts the instruction in execute.
            ERR <= (prio_cause == MEMF) ? PC_M : PC_E;
            ESR <= prio_cause;
            IE  <= 1'b0;
            cnt <= '0;
          end
        end
        FLUSH: cnt <= cnt + 1'b1;
        HANDLER: begin
          if (prio_vld) begin
            ESR <= prio_cause;
          end else if (ERet_E) begin
            ESR <= NONE;
            IE  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pipeline control outputs decoded from state and current inputs.
  always_comb begin
    IrqAck      = 1'b0;
    Flush_D     = 1'b0;
    Flush_E     = 1'b0;
    Flush_M     = 1'b0;
    Stall_F     = 1'b0;
    ExcRedirect = 1'b0;
    ExcPC       = '0;
    Halt        = 1'b0;
    case (state)
      RUN: begin
        if (prio_vld) begin
          Flush_D = 1'b1;
          Flush_E = 1'b1;
          Stall_F = 1'b1;
          // A memory fault keeps EX/MEM so the faulting op is squashed a
          // cycle later by the FLUSH state.
          Flush_M = (prio_cause != MEMF);
          IrqAck  = (prio_cause == IRQ);
        end
      end
      FLUSH: begin
        Flush_D = 1'b1;
        Flush_E = 1'b1;
        Flush_M = 1'b1;
        Stall_F = 1'b1;
      end
      REDIRECT: begin
        ExcRedirect = 1'b1;
        ExcPC       = VECTOR;
        Flush_D     = 1'b1;
      end
      HANDLER: begin
        if (!prio_vld && ERet_E) begin
          ExcRedirect = 1'b1;
          ExcPC       = ERR;
          Flush_D     = 1'b1;
          Flush_E     = 1'b1;
        end
      end
      HALT: begin
        Halt    = 1'b1;
        Stall_F = 1'b1;
        Flush_D = 1'b1;
        Flush_E = 1'b1;
        Flush_M = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Randomized self-checking bench for exception_ctrl with a behavioural model.
module tb_exception_ctrl;

  localparam int          N     = 64;
  localparam logic [63:0] VEC   = 64'hD8;
  localparam int          FLUSH = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         MemFault_M, BadOpcode_E, ERet_E, ExtIRQ;
  logic [N-1:0] PC_E, PC_M;
  logic         IrqAck, Flush_D, Flush_E, Flush_M, Stall_F, ExcRedirect, IE, Halt;
  logic [N-1:0] ExcPC, ERR;
  logic [3:0]   ESR;

  exception_ctrl #(.N(N), .VECTOR(VEC), .FLUSH_CYCLES(FLUSH)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemFault_M  (MemFault_M),
    .BadOpcode_E (BadOpcode_E),
    .ERet_E      (ERet_E),
    .ExtIRQ      (ExtIRQ),
    .PC_E        (PC_E),
    .PC_M        (PC_M),
    .IrqAck      (IrqAck),
    .Flush_D     (Flush_D),
    .Flush_E     (Flush_E),
    .Flush_M     (Flush_M),
    .Stall_F     (Stall_F),
    .ExcRedirect (ExcRedirect),
    .ExcPC       (ExcPC),
    .ERR         (ERR),
    .ESR         (ESR),
    .IE          (IE),
    .Halt        (Halt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt  = 0;

  // Behavioural model: mode flags plus a count of flush cycles still owed.
  int          m_flush_left;
  bit          m_redirect, m_handler, m_halted;
  logic [63:0] m_err;
  logic [3:0]  m_esr;
  bit          m_ie;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flush_left = 0;
    m_redirect   = 0;
    m_handler    = 0;
    m_halted     = 0;
    m_err        = '0;
    m_esr        = 4'd0;
    m_ie         = 1'b1;
  endtask

  // One clock: drive inputs, check every output against the model, then
  // advance the model across the rising edge.
  task automatic step(input bit rn, input bit mf, input bit bo, input bit er,
                      input bit irq, input logic [63:0] pe, input logic [63:0] pm);
    bit          e_fd, e_fe, e_fm, e_st, e_red, e_ack, e_halt;
    logic [63:0] e_pc;
    int          c;
    bit          running;
    @(negedge clk);
    reset = rn; MemFault_M = mf; BadOpcode_E = bo; ERet_E = er; ExtIRQ = irq;
    PC_E = pe; PC_M = pm;
    #2;
    e_fd = 0; e_fe = 0; e_fm = 0; e_st = 0; e_red = 0; e_ack = 0; e_halt = 0;
    e_pc = '0;
    c = 0;
    running = !m_halted && m_flush_left == 0 && !m_redirect && !m_handler;
    if (m_halted) begin
      e_halt = 1; e_st = 1; e_fd = 1; e_fe = 1; e_fm = 1;
    end else if (m_flush_left > 0) begin
      e_fd = 1; e_fe = 1; e_fm = 1; e_st = 1;
    end else if (m_redirect) begin
      e_red = 1; e_pc = VEC; e_fd = 1;
    end else if (m_handler) begin
      if (!(mf || bo) && er) begin
        e_red = 1; e_pc = m_err; e_fd = 1; e_fe = 1;
      end
    end else begin
      if (mf) c = 3;
      else if (bo) c = 1;
      else if (er) c = 4;
      else if (irq && m_ie) c = 2;
      if (c != 0) begin
        e_fd = 1; e_fe = 1; e_st = 1;
        e_fm = (c != 3);
        e_ack = (c == 2);
      end
    end
    chk("IrqAck", IrqAck, e_ack);
    chk("Flush_D", Flush_D, e_fd);
    chk("Flush_E", Flush_E, e_fe);
    chk("Flush_M", Flush_M, e_fm);
    chk("Stall_F", Stall_F, e_st);
    chk("ExcRedirect", ExcRedirect, e_red);
    chk("ExcPC", ExcPC, e_pc);
    chk("ERR", ERR, m_err);
    chk("ESR", ESR, m_esr);
    chk("IE", IE, m_ie);
    chk("Halt", Halt, e_halt);
    if (IrqAck === 1'b1) ack_cnt++;
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else if (m_halted) begin
      // stays halted
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      if (m_flush_left == 0) m_redirect = 1;
    end else if (m_redirect) begin
      m_redirect = 0;
      m_handler  = 1;
    end else if (m_handler) begin
      if (mf || bo) begin
        m_esr     = mf ? 4'd3 : 4'd1;
        m_handler = 0;
        m_halted  = 1;
      end else if (er) begin
        m_handler = 0;
        m_ie      = 1;
        m_esr     = 4'd0;
      end
    end else if (running && c != 0) begin
      m_err        = (c == 3) ? pm : pe;
      m_esr        = 4'(c);
      m_ie         = 0;
      m_flush_left = FLUSH;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 64'h0, 64'h0);
  endtask

  initial begin
    reset = 0; MemFault_M = 0; BadOpcode_E = 0; ERet_E = 0; ExtIRQ = 0;
    PC_E = '0; PC_M = '0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;

    // Reset state with quiet inputs.
    idle(1);

    // Bad opcode at 0x40: event, two flush cycles, redirect to vector.
    step(1, 0, 1, 0, 0, 64'h40, 64'h0);
    idle(FLUSH + 1);
    chk("badop_ERR", ERR, 64'h40);
    chk("badop_ESR", ESR, 4'd1);
    chk("badop_IE", IE, 1'b0);
    idle(2);
    step(1, 0, 0, 1, 0, 64'h0, 64'h0);

    // Held interrupt: a single acknowledge, none while in the handler.
    ack_cnt = 0;
    step(1, 0, 0, 0, 1, 64'h100, 64'h0);
    chk("irq_ESR", ESR, 4'd2);
    for (int i = 0; i < FLUSH + 4; i++) step(1, 0, 0, 0, 1, 64'h200, 64'h0);
    chk("irq_ack_once", ack_cnt, 1);
    step(1, 0, 0, 1, 0, 64'h300, 64'h0);
    chk("irq_ret_IE", IE, 1'b1);

    // Simultaneous memory fault and bad opcode: memory fault wins.
    step(1, 1, 1, 0, 0, 64'h80, 64'h7C);
    chk("memf_ESR", ESR, 4'd3);
    chk("memf_ERR", ERR, 64'h7C);
    idle(FLUSH + 1);
    step(1, 0, 0, 1, 0, 64'h0, 64'h0);

    // ERET while running is treated as an exception.
    step(1, 0, 0, 1, 0, 64'h20, 64'h0);
    chk("eretrun_ESR", ESR, 4'd4);
    chk("eretrun_ERR", ERR, 64'h20);
    idle(FLUSH + 1);

    // Double fault in the handler, with a simultaneous ERET, halts.
    step(1, 0, 1, 1, 0, 64'h44, 64'h0);
    chk("dbl_Halt", Halt, 1'b1);
    chk("dbl_ESR", ESR, 4'd1);
    chk("dbl_ERR", ERR, 64'h20);
    for (int i = 0; i < 4; i++)
      step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 64'h0, 64'h0);
    step(0, 0, 0, 0, 0, 64'h0, 64'h0);
    chk("halt_reset_IE", IE, 1'b1);
    idle(1);

    // Reset during the second flush cycle: no redirect afterwards.
    step(1, 0, 1, 0, 0, 64'h60, 64'h0);
    idle(1);
    step(0, 0, 0, 0, 0, 64'h0, 64'h0);
    chk("midflush_ERR", ERR, 64'h0);
    chk("midflush_ESR", ESR, 4'd0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0),
           {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
- Sequences the pipeline around the execute stage when an exception or interrupt is taken, and when the handler returns.
- Prioritises exception sources and latches the return PC (ERR) and cause (ESR).
- Drives pipeline flushes, then redirects the PC to the exception vector.
- On ERET, redirects back to ERR and re-enables interrupts.
- Sits beside the hazard unit; its redirect feeds the fetch PC mux ahead of PCBranch_E.

Parameters:
- N, 64, datapath/PC width
- VECTOR, 64'hD8, handler entry address
- FLUSH_CYCLES, 2, cycles spent in FLUSH (1..7)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- MemFault_M  in  1  memory-stage access fault
- BadOpcode_E  in  1  invalid instruction in execute
- ERet_E  in  1  ERET instruction in execute
- ExtIRQ  in  1  external interrupt, level-sensitive
- PC_E  in  N  PC of instruction in execute
- PC_M  in  N  PC of instruction in memory
- IrqAck  out  1  one-cycle pulse when ExtIRQ is accepted
- Flush_D  out  1  flush IF/ID register
- Flush_E  out  1  flush ID/EX register
- Flush_M  out  1  flush EX/MEM register
- Stall_F  out  1  hold PC register
- ExcRedirect  out  1  select ExcPC as next PC
- ExcPC  out  N  redirect target
- ERR  out  N  exception return register
- ESR  out  4  cause code
- IE  out  1  interrupt enable
- Halt  out  1  double-fault halt

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=RUN, counter=0, ERR=0, ESR=0, IE=1.
  - All other outputs are 0.
  - Reset has priority over everything, including mid-FLUSH, HANDLER and HALT.
- Cause codes: NONE=0, BADOP=1, IRQ=2, MEMF=3, ERET_RUN=4.
- RUN state:
  - Priority: MemFault_M > BadOpcode_E > ERet_E (illegal in RUN) > ExtIRQ&IE.
  - Event in cycle T, combinational outputs in T:
    - Flush_D=Flush_E=Stall_F=1.
    - Flush_M=1 for all causes except MEMF. For MEMF, EX/MEM holds the faulting op and is squashed next cycle.
  - Registered at the end of T:
    - ERR = PC_M for MEMF, otherwise PC_E. For IRQ, the instruction in E is restarted.
    - ESR = cause, IE=0, counter=0, state=FLUSH.
  - IRQ only: IrqAck=1 in cycle T.
- FLUSH state:
  - Flush_D=Flush_E=Flush_M=Stall_F=1.
  - Counter increments each cycle; leave when counter==FLUSH_CYCLES-1, to REDIRECT.
  - Inputs are ignored.
- REDIRECT state, exactly 1 cycle:
  - ExcRedirect=1, ExcPC=VECTOR, Flush_D=1, Stall_F=0.
  - Next state: HANDLER.
- HANDLER state:
  - Normal execution; ExtIRQ is ignored (IE=0).
  - ERet_E, with no fault that cycle: combinational ExcRedirect=1, ExcPC=ERR, Flush_D=Flush_E=1. Registered: IE=1, ESR=0, state=RUN. ERR is retained.
  - MemFault_M or BadOpcode_E: double fault. Set ESR to the new cause (ERR unchanged), then state=HALT. Fault beats a simultaneous ERet.
- HALT state:
  - Halt=1, Stall_F=1, Flush_D=Flush_E=Flush_M=1.
  - Stays in HALT until reset.
- General rules:
  - ExcPC=0 whenever ExcRedirect=0.
  - Outputs not listed for a state are 0.
  - Counter width is 3 bits; FLUSH_CYCLES outside 1..7 is illegal (elaboration assertion).

Decomposition:
- Package exc_pkg:
  - state enum {RUN, FLUSH, REDIRECT, HANDLER, HALT}
  - cause localparams (NONE, BADOP, IRQ, MEMF, ERET_RUN)
  - default VECTOR
- Sub-module exc_prio: purely combinational priority encoder. Inputs are the four sources plus IE; outputs are valid and cause[3:0]. It is reused for future sources.
- The FSM, ERR/ESR/IE registers and flush counter live in exception_ctrl.

Test Plan:
- Reset, then BadOpcode_E=1 with PC_E=0x40 in cycle T:
  - Flush_D/E/M=1 in T, then 2 FLUSH cycles.
  - REDIRECT with ExcPC=0xD8.
  - ERR=0x40, ESR=1, IE=0.
- ExtIRQ held high, PC_E=0x100:
  - IrqAck pulses exactly once, ESR=2.
  - While in HANDLER with ExtIRQ still high: no second ack.
  - ERet_E: ExcRedirect=1, ExcPC=0x100, then IE=1 and state RUN.
- Same cycle MemFault_M (PC_M=0x7C) and BadOpcode_E (PC_E=0x80):
  - ESR=3, ERR=0x7C.
  - Flush_M=0 in T.
- ERet_E in RUN with PC_E=0x20:
  - ESR=4, ERR=0x20, handler entry at 0xD8.
- Double fault, BadOpcode_E during HANDLER:
  - Halt=1, ESR=1, ERR unchanged.
  - State stays HALT until reset=0. After reset: all outputs 0, IE=1.
- reset=0 asserted during the second FLUSH cycle:
  - Next cycle: state RUN, no REDIRECT pulse, ERR=0, ESR=0.
